reg_pipe: RTL and testbench

//  Parametrised elastic pipeline register: DEPTH stages of WIDTH-bit data, each stage with a valid bit.

---
 rtl/reg_pipe.sv | 132 +++++++++++++
 tb/tb_reg_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_pipe.sv
// ---------------------------------------------------------------------------
// reg_pipe -- elastic pipeline register
//
// DEPTH stages of WIDTH-bit data, each with its own valid bit. Words move
// toward the output whenever the stage ahead is empty or is itself moving,
// so empty stages close up even while the consumer stalls. The ready chain is
// purely combinational from out_ready back to in_ready. This gives one word
// per cycle of sustained throughput with no inserted bubbles.
//
// Ports
//   Clk        in   1      clock, all state updates on posedge
//   Rst        in   1      synchronous reset, active-high (clears valid, data, count)
//   Flush      in   1      synchronous clear of valid bits and count; data holds
//   in_valid   in   1      producer offers in_data
//   in_ready   out  1      pipe accepts in_data this cycle
//   in_data    in   WIDTH  input word
//   out_valid  out  1      last stage holds a valid word
//   out_ready  in   1      consumer takes out_data this cycle
//   out_data   out  WIDTH  word in stage DEPTH-1
//   count      out  CNTW   number of valid stages, 0..DEPTH
// ---------------------------------------------------------------------------
module reg_pipe #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  count
);

  logic [DEPTH-1:0] valid_r;
  logic [WIDTH-1:0] data_r [DEPTH];
  logic [CNTW-1:0]  count_r;

  logic [DEPTH-1:0] adv_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             leave_s;

  // Ready/advance chain, walked from the output stage back to the input.
  // 'room' means the stage ahead of the current one can take a word this cycle.
  always_comb begin
    logic room_s;
    logic adv_bit_s;
    room_s    = out_ready;
    adv_bit_s = 1'b0;
    adv_s     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv_bit_s = valid_r[i] & room_s;
      adv_s[i]  = adv_bit_s;
      room_s    = ~valid_r[i] | adv_bit_s;
    end
    in_ready_s = room_s;
  end

  assign accept_s = in_valid & in_ready_s;
  assign leave_s  = adv_s[DEPTH-1];

  // Valid bits and occupancy count.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_r <= '0;
      count_r <= '0;
    end else if (Flush) begin
      // Any word offered this cycle is dropped along with the contents.
      valid_r <= '0;
      count_r <= '0;
    end else begin
      if (accept_s) begin
        valid_r[0] <= 1'b1;
      end else if (adv_s[0]) begin
        valid_r[0] <= 1'b0;
      end else begin
        valid_r[0] <= valid_r[0];
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv_s[i-1]) begin
          valid_r[i] <= 1'b1;
        end else if (adv_s[i]) begin
          valid_r[i] <= 1'b0;
        end else begin
          valid_r[i] <= valid_r[i];
        end
      end
      case ({accept_s, leave_s})
        2'b10:   count_r <= count_r + CNTW'(1);
        2'b01:   count_r <= count_r - CNTW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Data registers: load only when a word moves in, so a stalled output is stable.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= '0;
      end
    end else if (Flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= data_r[i];
      end
    end else begin
      if (accept_s) begin
        data_r[0] <= in_data;
      end else begin
        data_r[0] <= data_r[0];
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv_s[i-1]) begin
          data_r[i] <= data_r[i-1];
        end else begin
          data_r[i] <= data_r[i];
        end
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = valid_r[DEPTH-1];
  assign out_data  = data_r[DEPTH-1];
  assign count     = count_r;

endmodule

// File: tb/tb_reg_pipe.sv
// ---------------------------------------------------------------------------
// tb_reg_pipe -- directed self-checking bench for reg_pipe (WIDTH=32, DEPTH=4)
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_reg_pipe;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic             Clk = 1'b0;
  logic             Rst = 1'b0;
  logic             Flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CNTW-1:0]  count;

  int checks   = 0;
  int failures = 0;

  reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .Flush(Flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; out_ready = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    Rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_streaming();
    int pushed = 0;
    int got = 0;
    int first = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 16; c++) begin
      in_valid = (pushed < 16);
      in_data  = 32'(pushed + 1);
      #1;
      if (in_valid) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", c, in_ready); end
        pushed++;
      end
      if (out_valid === 1'b1) begin
        if (first < 0) first = c;
        checks++; if (out_data !== 32'(got + 1)) begin failures++; $display("FAIL stream_order got=%h exp=%h", out_data, 32'(got + 1)); end
        got++;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (first !== 4) begin failures++; $display("FAIL stream_latency got=%0d exp=4", first); end
    checks++; if (got !== 16) begin failures++; $display("FAIL stream_words got=%0d exp=16", got); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL stream_count_end got=%0d exp=0", count); end
  endtask

  task automatic test_backpressure();
    logic [31:0] words [5];
    words[0] = 32'hDEAD_BEEF; words[1] = 32'h11; words[2] = 32'h22;
    words[3] = 32'h33; words[4] = 32'h44;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = words[i];
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept%0d got=%b exp=1", i, in_ready); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = words[4];
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", count); end
      checks++; if (out_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bp_hold got=%h exp=deadbeef", out_data); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== words[i]) begin
        failures++; $display("FAIL bp_drain%0d got=%b/%h exp=1/%h", i, out_valid, out_data, words[i]);
      end
      tick();
    end
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0d/%b exp=0/0", count, out_valid); end
  endtask

  task automatic test_bubble_collapse();
    logic [31:0] exp_w [3];
    logic        push [8];
    logic [31:0] val  [8];
    int k = 0;
    exp_w[0] = 32'hA; exp_w[1] = 32'hB; exp_w[2] = 32'hC;
    // A, idle, idle, B, idle, C, then settle
    for (int c = 0; c < 8; c++) begin push[c] = 1'b0; val[c] = 32'h0; end
    push[0] = 1'b1; val[0] = 32'hA;
    push[3] = 1'b1; val[3] = 32'hB;
    push[5] = 1'b1; val[5] = 32'hC;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = push[c]; in_data = val[c];
      tick();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL bubble_count got=%0d exp=3", count); end
    checks++; if (out_data !== 32'hA || out_valid !== 1'b1) begin failures++; $display("FAIL bubble_head got=%b/%h exp=1/a", out_valid, out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== exp_w[i]) begin
        failures++; $display("FAIL bubble_release%0d got=%b/%h exp=1/%h", i, out_valid, out_data, exp_w[i]);
      end
      k++;
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bubble_after got=%b exp=0 n=%0d", out_valid, k); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + 32'(i);
      tick();
    end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL b2b_fill got=%0d exp=4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 32'h104 + 32'(i);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=1", i, in_ready); end
      checks++; if (out_data !== 32'h100 + 32'(i)) begin failures++; $display("FAIL b2b_order%0d got=%h exp=%h", i, out_data, 32'h100 + 32'(i)); end
      tick();
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL b2b_count%0d got=%0d exp=4", i, count); end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (out_data !== 32'h10A + 32'(i)) begin failures++; $display("FAIL b2b_drain%0d got=%h exp=%h", i, out_data, 32'h10A + 32'(i)); end
      tick();
    end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL b2b_empty got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    int first = -1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'(i + 1);
      tick();
    end
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
    Flush = 1'b1; in_valid = 1'b1; in_data = 32'h55;
    tick();
    Flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 0); in_data = 32'h77;
      #1;
      if (out_valid === 1'b1) begin
        if (first < 0) first = c;
        checks++; if (out_data !== 32'h77) begin failures++; $display("FAIL flush_word got=%h exp=77", out_data); end
      end
      tick();
    end
    in_valid = 1'b0;
    checks++; if (first !== 4) begin failures++; $display("FAIL flush_latency got=%0d exp=4", first); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble_collapse();
    test_back_to_back();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
